// File: rtl/mopshub_test_sequencer_pkg.sv
// State codes and counter sizing shared by the MOPS-Hub test-phase sequencer.
package mopshub_seq_pkg;

    localparam logic [3:0] ST_ERR = 4'hF;

    typedef enum logic [3:0] {
        SEQ_IDLE        = 4'd0,
        SEQ_TRIM        = 4'd1,
        SEQ_WAIT_SIGNON = 4'd2,
        SEQ_RX          = 4'd3,
        SEQ_ENDWAIT     = 4'd4,
        SEQ_GAP         = 4'd5,
        SEQ_TX          = 4'd6,
        SEQ_ADV         = 4'd7,
        SEQ_NEXT        = 4'd8,
        SEQ_DONE        = 4'd9,
        SEQ_ERR         = ST_ERR
    } seq_state_t;

    // Bits needed to hold every value 0..max_val, never fewer than one.
    function automatic int cnt_width(input int unsigned max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/mopshub_test_sequencer_timer.sv
// Saturating up-counter with synchronous clear; o_expire is high once the
// count has reached i_limit, and the count then holds instead of wrapping.
module seq_timer #(
    parameter int CNT_W = 8
) (
    input  logic             clk_40_m,
    input  logic             rst,
    input  logic             i_clr,
    input  logic             i_en,
    input  logic [CNT_W-1:0] i_limit,
    output logic             o_expire
);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk_40_m) begin
        if (!rst || i_clr) begin
            r_cnt <= '0;
        end else if (i_en && (r_cnt < i_limit)) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign o_expire = (r_cnt >= i_limit);

endmodule

// File: rtl/mopshub_test_sequencer.sv
// Test-phase sequencer feeding data_generator / mopshub_top, with per-phase watchdog.
// Define MOPSHUB_SEQ_LOOP_EN to walk bus_sel through all N_BUSES before finishing.
module mopshub_test_sequencer
    import mopshub_seq_pkg::*;
#(
    parameter logic [4:0]  N_BUSES        = 5'd1,
    parameter int unsigned TX_GAP_CYCLES  = 120,
    parameter int unsigned ENDWAIT_CYCLES = 1,
    parameter int unsigned TIMEOUT_CYCLES = 2**20
) (
    input  logic       clk_40_m,
    input  logic       rst,
    input  logic       trim_req,
    input  logic       adv_req,
    input  logic       end_power_init,
    input  logic       sign_on_sig,
    input  logic       test_rx_end,
    input  logic       test_tx_end,
    input  logic       costum_msg_end,
    output logic       osc_auto_trim_mopshub,
    output logic       test_rx,
    output logic       test_tx,
    output logic       test_advanced,
    output logic       endwait_all,
    output logic [4:0] bus_sel,
    output logic [3:0] phase,
    output logic       done,
    output logic       timeout_err
);

    localparam int unsigned GAP_MAX = (TX_GAP_CYCLES > ENDWAIT_CYCLES) ? TX_GAP_CYCLES : ENDWAIT_CYCLES;
    localparam int GT_W = cnt_width(GAP_MAX);
    localparam int WD_W = cnt_width(TIMEOUT_CYCLES);
    localparam logic [GT_W-1:0] EW_LIMIT  = GT_W'(ENDWAIT_CYCLES - 1);
    localparam logic [GT_W-1:0] GAP_LIMIT = (TX_GAP_CYCLES == 0) ? '0 : GT_W'(TX_GAP_CYCLES - 1);
    localparam logic [WD_W-1:0] WD_LIMIT  = WD_W'(TIMEOUT_CYCLES - 1);

    if (N_BUSES == 5'd0 || ENDWAIT_CYCLES == 0 || TIMEOUT_CYCLES == 0) begin : g_param_check
        $error("mopshub_test_sequencer: N_BUSES, ENDWAIT_CYCLES and TIMEOUT_CYCLES must be nonzero");
    end

    seq_state_t      r_state;
    seq_state_t      w_next;
    logic [4:0]      w_bus;
    logic            w_state_chg;
    logic            w_gap_en;
    logic            w_gap_exp;
    logic [GT_W-1:0] w_gap_limit;
    logic            w_wd_en;
    logic            w_wd_exp;

    logic            r_trim;
    logic            r_rx;
    logic            r_tx;
    logic            r_adv;
    logic            r_endwait;
    logic [4:0]      r_bus_sel;
    logic [3:0]      r_phase;
    logic            r_done;
    logic            r_timeout;

`ifdef MOPSHUB_SEQ_LOOP_EN
    logic [4:0] r_bus;
    logic       w_more_buses;

    assign w_more_buses = (({1'b0, r_bus} + 6'd1) < {1'b0, N_BUSES});

    // Bus index only moves in NEXT, so it stays frozen through ERR and DONE.
    always_ff @(posedge clk_40_m) begin
        if (!rst) begin
            r_bus <= '0;
        end else if (r_state == SEQ_NEXT && w_more_buses) begin
            r_bus <= r_bus + 5'd1;
        end
    end

    assign w_bus = r_bus;
`else
    assign w_bus = 5'd0;
`endif

    // Exit strobes are tested before watchdog expiry so a coincident strobe wins.
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            SEQ_IDLE:        w_next = trim_req ? SEQ_TRIM : SEQ_WAIT_SIGNON;
            SEQ_TRIM:        if (end_power_init) w_next = SEQ_WAIT_SIGNON;
                             else if (w_wd_exp)  w_next = SEQ_ERR;
            SEQ_WAIT_SIGNON: if (sign_on_sig)    w_next = SEQ_RX;
                             else if (w_wd_exp)  w_next = SEQ_ERR;
            SEQ_RX:          if (test_rx_end)    w_next = SEQ_ENDWAIT;
                             else if (w_wd_exp)  w_next = SEQ_ERR;
            SEQ_ENDWAIT:     if (w_gap_exp)      w_next = SEQ_GAP;
            SEQ_GAP:         if (w_gap_exp)      w_next = SEQ_TX;
            SEQ_TX:          if (test_tx_end)    w_next = adv_req ? SEQ_ADV : SEQ_NEXT;
                             else if (w_wd_exp)  w_next = SEQ_ERR;
            SEQ_ADV:         if (costum_msg_end) w_next = SEQ_NEXT;
                             else if (w_wd_exp)  w_next = SEQ_ERR;
`ifdef MOPSHUB_SEQ_LOOP_EN
            SEQ_NEXT:        w_next = w_more_buses ? SEQ_WAIT_SIGNON : SEQ_DONE;
`else
            SEQ_NEXT:        w_next = SEQ_DONE;
`endif
            SEQ_DONE:        w_next = SEQ_DONE;
            SEQ_ERR:         w_next = SEQ_ERR;
            default:         w_next = SEQ_IDLE;
        endcase
    end

    always_ff @(posedge clk_40_m) begin
        if (!rst) begin
            r_state <= SEQ_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    assign w_state_chg = (w_next != r_state);
    assign w_gap_en    = (r_state == SEQ_ENDWAIT) || (r_state == SEQ_GAP);
    assign w_gap_limit = (r_state == SEQ_ENDWAIT) ? EW_LIMIT : GAP_LIMIT;
    assign w_wd_en     = (r_state == SEQ_TRIM) || (r_state == SEQ_WAIT_SIGNON) ||
                         (r_state == SEQ_RX)   || (r_state == SEQ_TX) || (r_state == SEQ_ADV);

    seq_timer #(.CNT_W(GT_W)) u_gap_timer (
        .clk_40_m (clk_40_m),
        .rst      (rst),
        .i_clr    (w_state_chg),
        .i_en     (w_gap_en),
        .i_limit  (w_gap_limit),
        .o_expire (w_gap_exp)
    );

    seq_timer #(.CNT_W(WD_W)) u_wd_timer (
        .clk_40_m (clk_40_m),
        .rst      (rst),
        .i_clr    (w_state_chg),
        .i_en     (w_wd_en),
        .i_limit  (WD_LIMIT),
        .o_expire (w_wd_exp)
    );

    // Outputs decode the current state one clock late so every pin is a flop.
    always_ff @(posedge clk_40_m) begin
        if (!rst) begin
            r_trim    <= 1'b0;
            r_rx      <= 1'b0;
            r_tx      <= 1'b0;
            r_adv     <= 1'b0;
            r_endwait <= 1'b0;
            r_bus_sel <= '0;
            r_phase   <= '0;
            r_done    <= 1'b0;
            r_timeout <= 1'b0;
        end else begin
            r_trim    <= (r_state == SEQ_TRIM);
            r_rx      <= (r_state == SEQ_RX);
            r_tx      <= (r_state == SEQ_TX);
            r_adv     <= (r_state == SEQ_ADV);
            r_endwait <= (r_state == SEQ_ENDWAIT);
            r_bus_sel <= w_bus;
            r_phase   <= r_state;
            r_done    <= (r_state == SEQ_DONE);
            r_timeout <= (r_state == SEQ_ERR);
        end
    end

    assign osc_auto_trim_mopshub = r_trim;
    assign test_rx               = r_rx;
    assign test_tx               = r_tx;
    assign test_advanced         = r_adv;
    assign endwait_all           = r_endwait;
    assign bus_sel               = r_bus_sel;
    assign phase                 = r_phase;
    assign done                  = r_done;
    assign timeout_err           = r_timeout;

endmodule

// File: tb/tb_mopshub_test_sequencer.sv
// Bench for mopshub_test_sequencer: a phase timeline built from the stimulus
// schedule predicts every output on every cycle, plus literal spot checks.
module tb_mopshub_test_sequencer;

    localparam int GAP  = 120;
    localparam int EW   = 1;
    localparam int TO_B = 64;
    localparam int MAXC = 1700;
`ifdef MOPSHUB_SEQ_LOOP_EN
    localparam int ROUNDS = 3;
`else
    localparam int ROUNDS = 1;
`endif

    logic clk_40_m = 1'b0;
    always #5 clk_40_m = ~clk_40_m;

    logic rst_a = 1'b0, rst_b = 1'b0;
    logic trim_req = 1'b0, adv_req = 1'b0, end_power_init = 1'b0, sign_on_sig = 1'b0;
    logic test_rx_end = 1'b0, test_tx_end = 1'b0, costum_msg_end = 1'b0;

    logic a_trim, a_rx, a_tx, a_adv, a_ew, a_done, a_terr;
    logic [4:0] a_bus;
    logic [3:0] a_phase;
    logic b_trim, b_rx, b_tx, b_adv, b_ew, b_done, b_terr;
    logic [4:0] b_bus;
    logic [3:0] b_phase;

    mopshub_test_sequencer #(.N_BUSES(5'd3), .TX_GAP_CYCLES(GAP), .ENDWAIT_CYCLES(EW)) dut_a (
        .clk_40_m(clk_40_m), .rst(rst_a), .trim_req(trim_req), .adv_req(adv_req),
        .end_power_init(end_power_init), .sign_on_sig(sign_on_sig), .test_rx_end(test_rx_end),
        .test_tx_end(test_tx_end), .costum_msg_end(costum_msg_end),
        .osc_auto_trim_mopshub(a_trim), .test_rx(a_rx), .test_tx(a_tx), .test_advanced(a_adv),
        .endwait_all(a_ew), .bus_sel(a_bus), .phase(a_phase), .done(a_done), .timeout_err(a_terr)
    );

    mopshub_test_sequencer #(.TX_GAP_CYCLES(GAP), .ENDWAIT_CYCLES(EW), .TIMEOUT_CYCLES(TO_B)) dut_b (
        .clk_40_m(clk_40_m), .rst(rst_b), .trim_req(trim_req), .adv_req(adv_req),
        .end_power_init(end_power_init), .sign_on_sig(sign_on_sig), .test_rx_end(test_rx_end),
        .test_tx_end(test_tx_end), .costum_msg_end(costum_msg_end),
        .osc_auto_trim_mopshub(b_trim), .test_rx(b_rx), .test_tx(b_tx), .test_advanced(b_adv),
        .endwait_all(b_ew), .bus_sel(b_bus), .phase(b_phase), .done(b_done), .timeout_err(b_terr)
    );

    // Expected phase and bus for each cycle, plus the strobe schedule that produces it.
    int exp_st [MAXC];
    int exp_bus[MAXC];
    bit s_epi[MAXC], s_sign[MAXC], s_rxe[MAXC], s_txe[MAXC], s_cme[MAXC];
    int wp, seq_len;
    bit trim_v, adv_v;

    int checks = 0, failures = 0;
    bit chk_en = 1'b0, sel_b = 1'b0;
    int cur_c = 0, run_id = 0;

    task automatic clr_tl();
        wp = 0;
        for (int i = 0; i < MAXC; i++) begin
            exp_st[i] = 0; exp_bus[i] = 0;
            s_epi[i] = 0; s_sign[i] = 0; s_rxe[i] = 0; s_txe[i] = 0; s_cme[i] = 0;
        end
    endtask

    task automatic put(int st, int len, int bus);
        for (int i = 0; i < len; i++) begin
            exp_st[wp] = st; exp_bus[wp] = bus; wp++;
        end
    endtask

    // Phase codes: 0 idle, 1 trim, 2 wait sign-on, 3 rx, 4 endwait, 5 gap,
    // 6 tx, 7 adv, 8 next, 9 done, 15 error. Out-of-state strobes are sprinkled in.
    task automatic build_a(bit trim, bit adv, int wl, int rl, int tl, int al, int rounds);
        clr_tl();
        trim_v = trim; adv_v = adv;
        put(0, 1, 0);
        if (trim) begin
            put(1, 50, 0); s_epi[wp-1] = 1; s_sign[10] = 1;
        end
        for (int r = 0; r < rounds; r++) begin
            s_epi[wp] = 1;
            put(2, wl, r);  s_sign[wp-1] = 1;
            put(3, rl, r);  s_rxe[wp-1] = 1; s_txe[wp-rl+2] = 1; s_cme[wp-rl+3] = 1;
            put(4, EW, r);
            put(5, GAP, r); s_rxe[wp-3] = 1; s_sign[wp-2] = 1;
            put(6, tl, r);  s_txe[wp-1] = 1; s_cme[wp-tl+1] = 1;
            if (adv) begin
                put(7, al, r); s_cme[wp-1] = 1; s_txe[wp-al+1] = 1;
            end
            put(8, 1, r);
        end
        seq_len = wp;
        put(9, MAXC - wp, rounds - 1);
    endtask

    task automatic lit(string nm, int act, int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s run=%0d cyc=%0d actual=%0d required=%0d", nm, run_id, cur_c, act, req);
        end
    endtask

    always @(negedge clk_40_m) begin
        if (chk_en) begin
            int prev, pbus;
            logic [15:0] act, req;
            prev = (cur_c == 0) ? -1 : exp_st[cur_c-1];
            pbus = (cur_c == 0) ? 0 : exp_bus[cur_c-1];
            req = {prev == 1, prev == 3, prev == 6, prev == 7, prev == 4, prev == 9, prev == 15,
                   (prev < 0) ? 4'd0 : 4'(prev), 5'(pbus)};
            act = sel_b ? {b_trim, b_rx, b_tx, b_adv, b_ew, b_done, b_terr, b_phase, b_bus}
                        : {a_trim, a_rx, a_tx, a_adv, a_ew, a_done, a_terr, a_phase, a_bus};
            checks++;
            if (act !== req) begin
                failures++;
                $display("FAIL outs run=%0d cyc=%0d actual=%h required=%h (trim,rx,tx,adv,ew,done,terr,phase,bus)",
                         run_id, cur_c, act, req);
            end
        end
    end

    task automatic pin(int c, int n);
        case (run_id)
            1: begin
                if (c == 1)   lit("trim_c1", a_trim, 0);
                if (c == 2)   lit("trim_c2", a_trim, 1);
                if (c == 51)  lit("trim_c51", a_trim, 1);
                if (c == 52)  lit("trim_c52", a_trim, 0);
                if (c == 81)  lit("phase_c81", a_phase, 2);
                if (c == 82)  begin lit("phase_c82", a_phase, 3); lit("rx_c82", a_rx, 1); end
                if (c == 201) lit("ew_c201", a_ew, 0);
                if (c == 202) lit("ew_c202", a_ew, 1);
                if (c == 203) lit("ew_c203", a_ew, 0);
                if (c == 322) lit("tx_c322", a_tx, 0);
                if (c == 323) lit("tx_c323", a_tx, 1);
                if (c == 402) lit("adv_c402", a_adv, 1);
                if (c == 451) lit("adv_c451", a_adv, 1);
                if (c == 452) lit("adv_c452", a_adv, 0);
`ifdef MOPSHUB_SEQ_LOOP_EN
                if (c == 454) lit("bus_c454", a_bus, 1);
`else
                if (c == 454) lit("done_c454", a_done, 1);
`endif
                if (c == n - 1) begin lit("done_end", a_done, 1); lit("bus_end", a_bus, ROUNDS - 1); end
            end
            2: if (c == 20) lit("rx_before_abort", a_rx, 1);
            3: if (c == 0) begin lit("abort_phase", a_phase, 0); lit("abort_rx", a_rx, 0); end
            4: begin
                if (c == 65) begin lit("b1_phase_c65", b_phase, 2); lit("b1_terr_c65", b_terr, 0); end
                if (c == 66) begin lit("b1_phase_c66", b_phase, 15); lit("b1_terr_c66", b_terr, 1); end
            end
            5: begin
                if (c == 66)  lit("b2_rx_c66", b_rx, 1);
                if (c == 129) lit("b2_rx_c129", b_rx, 1);
                if (c == 130) begin lit("b2_rx_c130", b_rx, 0); lit("b2_phase_c130", b_phase, 15); end
            end
            default: ;
        endcase
    endtask

    task automatic do_reset(bit b);
        sel_b = b; chk_en = 1'b0; cur_c = 0;
        end_power_init = 0; sign_on_sig = 0; test_rx_end = 0; test_tx_end = 0; costum_msg_end = 0;
        if (b) rst_b = 1'b0; else rst_a = 1'b0;
        @(posedge clk_40_m); #1;
        chk_en = 1'b1;
        repeat (2) begin @(posedge clk_40_m); #1; end
        chk_en = 1'b0;
    endtask

    task automatic run(int n, int abort_at);
        for (int c = 0; c < n; c++) begin
            cur_c = c; chk_en = 1'b1;
            trim_req = trim_v; adv_req = adv_v;
            end_power_init = s_epi[c]; sign_on_sig = s_sign[c]; test_rx_end = s_rxe[c];
            test_tx_end = s_txe[c]; costum_msg_end = s_cme[c];
            if (sel_b) rst_b = (c != abort_at); else rst_a = (c != abort_at);
            @(negedge clk_40_m);
            pin(c, n);
            @(posedge clk_40_m); #1;
        end
        chk_en = 1'b0;
    endtask

    initial begin
        run_id = 1;
        build_a(1, 1, 30, 120, 79, 50, ROUNDS);
        do_reset(0);
        run(seq_len + 6, -1);

        run_id = 2;
        build_a(0, 0, 10, 15, 12, 0, ROUNDS);
        do_reset(0);
        run(21, 20);

        run_id = 3;
        build_a(0, 0, 10, 15, 12, 0, ROUNDS);
        run(seq_len + 6, -1);

        run_id = 4;
        rst_a = 1'b0;
        clr_tl(); trim_v = 0; adv_v = 0;
        put(0, 1, 0); put(2, TO_B, 0); put(15, 100, 0);
        do_reset(1);
        run(80, -1);

        run_id = 5;
        clr_tl(); trim_v = 0; adv_v = 0;
        put(0, 1, 0); put(2, TO_B, 0); s_sign[wp-1] = 1;
        put(3, TO_B, 0); put(15, 100, 0);
        do_reset(1);
        run(140, -1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
